// File: rtl/lct_fifo1_if.sv
// Bus bundle for lct_fifo1: candidate-address push side, head-entry read side and status.
interface lct_fifo1_if;
  logic        LCT;
  logic        PUSH;
  logic        POP;
  logic        ENBL50;
  logic        DISBL50;
  logic        PREBLKEND;
  logic [3:0]  LOADPBLK;
  logic [11:0] DIN;
  logic [2:0]  DSCAFULL;
  logic [3:0]  DOUT;
  logic [7:0]  NLCT;
  logic        LCT_PHASE;
  logic        FULL_1;
  logic        EMPT_B;
  logic        FULL;
  logic        DLSCAFULL;

  modport slave (
    input  LCT, PUSH, POP, ENBL50, DISBL50, PREBLKEND, LOADPBLK, DIN, DSCAFULL,
    output DOUT, NLCT, LCT_PHASE, FULL_1, EMPT_B, FULL, DLSCAFULL
  );

  modport master (
    output LCT, PUSH, POP, ENBL50, DISBL50, PREBLKEND, LOADPBLK, DIN, DSCAFULL,
    input  DOUT, NLCT, LCT_PHASE, FULL_1, EMPT_B, FULL, DLSCAFULL
  );
endinterface

// File: rtl/lct_fifo1.sv
// 16-deep LCT block-address FIFO with optional deferred commit and optional
// triplicated state (majority-voted, rewritten from the vote every cycle).
module lct_fifo1 #(
  parameter int TMR = 0
) (
  input logic        CLK,
  input logic        RST,
  lct_fifo1_if.slave bus
);
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned EW    = 6;
  localparam int unsigned NC    = (TMR != 0) ? 3 : 1;

  // Entry layout: {addr[3:0], scafull, phase}
  logic [EW-1:0] mem_q    [NC][DEPTH];
  logic [AW-1:0] wr_ptr_q [NC];
  logic [AW-1:0] rd_ptr_q [NC];
  logic [CW-1:0] cnt_q    [NC];
  logic          pend_q   [NC];
  logic          full_q   [NC];
  logic [EW-1:0] hold_q   [NC];

  logic [AW-1:0] wr_ptr_v, rd_ptr_v, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0] cnt_v, cnt_d;
  logic          pend_v, pend_d, full_v, full_d;
  logic [EW-1:0] hold_v, hold_d, head_mem_v, head_d, new_ent, wdata;
  logic          act, wr_req, wr_en, pop_en;
  logic [AW-1:0] sel_addr;
  logic          sel_sc;

  logic [3:0]    dout_q;
  logic [7:0]    nlct_q;
  logic          ph_q, sc_q, full1_q, emptb_q, fullo_q;
  logic          unused_loadpblk;

  assign unused_loadpblk = ^bus.LOADPBLK[2:0];

  if (TMR != 0) begin : g_tmr
    assign wr_ptr_v = (wr_ptr_q[0] & wr_ptr_q[1]) | (wr_ptr_q[0] & wr_ptr_q[2]) | (wr_ptr_q[1] & wr_ptr_q[2]);
    assign rd_ptr_v = (rd_ptr_q[0] & rd_ptr_q[1]) | (rd_ptr_q[0] & rd_ptr_q[2]) | (rd_ptr_q[1] & rd_ptr_q[2]);
    assign cnt_v    = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
    assign pend_v   = (pend_q[0] & pend_q[1]) | (pend_q[0] & pend_q[2]) | (pend_q[1] & pend_q[2]);
    assign full_v   = (full_q[0] & full_q[1]) | (full_q[0] & full_q[2]) | (full_q[1] & full_q[2]);
    assign hold_v   = (hold_q[0] & hold_q[1]) | (hold_q[0] & hold_q[2]) | (hold_q[1] & hold_q[2]);
    assign head_mem_v = (mem_q[0][rd_ptr_d] & mem_q[1][rd_ptr_d])
                      | (mem_q[0][rd_ptr_d] & mem_q[2][rd_ptr_d])
                      | (mem_q[1][rd_ptr_d] & mem_q[2][rd_ptr_d]);
  end else begin : g_simplex
    assign wr_ptr_v   = wr_ptr_q[0];
    assign rd_ptr_v   = rd_ptr_q[0];
    assign cnt_v      = cnt_q[0];
    assign pend_v     = pend_q[0];
    assign full_v     = full_q[0];
    assign hold_v     = hold_q[0];
    assign head_mem_v = mem_q[0][rd_ptr_d];
  end

  // Candidate select, write/pop arbitration and pointer/count update
  always_comb begin
    act      = bus.ENBL50 | bus.DISBL50;
    sel_addr = bus.DIN[3:0];
    sel_sc   = 1'b0;
    pend_d   = pend_v;
    hold_d   = hold_v;
    wr_req   = 1'b0;
    wdata    = '0;
    if (!bus.DSCAFULL[0]) begin
      sel_addr = bus.DIN[3:0];
    end else if (!bus.DSCAFULL[1]) begin
      sel_addr = bus.DIN[7:4];
    end else if (!bus.DSCAFULL[2]) begin
      sel_addr = bus.DIN[11:8];
    end else begin
      sel_sc   = 1'b1;
    end
    new_ent = {sel_addr, sel_sc, bus.LCT & bus.ENBL50};

    if (act) begin
      if (bus.PUSH) begin
        if (!bus.LOADPBLK[3]) begin
          wr_req = 1'b1;
          wdata  = new_ent;
        end else begin
          // A push while pending flushes the held entry and takes its place
          wr_req = pend_v;
          wdata  = hold_v;
          hold_d = new_ent;
          pend_d = 1'b1;
        end
      end else if (bus.PREBLKEND && pend_v) begin
        wr_req = 1'b1;
        wdata  = hold_v;
        pend_d = 1'b0;
      end
    end

    pop_en   = act & bus.POP & (cnt_v != '0);
    wr_en    = wr_req & ((cnt_v != CW'(DEPTH)) | pop_en);
    full_d   = full_v | (wr_req & (cnt_v == CW'(DEPTH)) & ~pop_en);
    wr_ptr_d = wr_en  ? wr_ptr_v + AW'(1) : wr_ptr_v;
    rd_ptr_d = pop_en ? rd_ptr_v + AW'(1) : rd_ptr_v;
    cnt_d    = cnt_v;
    if (wr_en && !pop_en) begin
      cnt_d = cnt_v + CW'(1);
    end else if (pop_en && !wr_en) begin
      cnt_d = cnt_v - CW'(1);
    end
  end

  // Next head entry; bypass when the entry being written becomes the head
  always_comb begin
    head_d = '0;
    if (cnt_d != '0) begin
      if (wr_en && (wr_ptr_v == rd_ptr_d)) begin
        head_d = wdata;
      end else begin
        head_d = head_mem_v;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int unsigned c = 0; c < NC; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        pend_q[c]   <= 1'b0;
        full_q[c]   <= 1'b0;
        hold_q[c]   <= '0;
      end
      dout_q  <= '0;
      ph_q    <= 1'b0;
      sc_q    <= 1'b0;
      nlct_q  <= '0;
      full1_q <= 1'b0;
      emptb_q <= 1'b0;
      fullo_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NC; c++) begin
        wr_ptr_q[c] <= wr_ptr_d;
        rd_ptr_q[c] <= rd_ptr_d;
        cnt_q[c]    <= cnt_d;
        pend_q[c]   <= pend_d;
        full_q[c]   <= full_d;
        hold_q[c]   <= hold_d;
      end
      dout_q  <= head_d[5:2];
      sc_q    <= head_d[1];
      ph_q    <= head_d[0];
      nlct_q  <= 8'(cnt_d);
      full1_q <= (cnt_d >= CW'(15));
      emptb_q <= (cnt_d != '0);
      fullo_q <= full_d;
    end
  end

  // Storage is not reset; reset only makes it unreachable
  always_ff @(posedge CLK) begin
    if (RST && wr_en) begin
      for (int unsigned c = 0; c < NC; c++) begin
        mem_q[c][wr_ptr_v] <= wdata;
      end
    end
  end

  assign bus.DOUT      = dout_q;
  assign bus.LCT_PHASE = ph_q;
  assign bus.DLSCAFULL = sc_q;
  assign bus.NLCT      = nlct_q;
  assign bus.FULL_1    = full1_q;
  assign bus.EMPT_B    = emptb_q;
  assign bus.FULL      = fullo_q;
endmodule

// File: tb/tb_lct_fifo1.sv
// Scoreboard bench for lct_fifo1, checking the simplex and triplicated builds side by side.
module tb_lct_fifo1;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  lct_fifo1_if bus0();
  lct_fifo1_if bus1();

  lct_fifo1 #(.TMR(0)) u_dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  lct_fifo1 #(.TMR(1)) u_dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of expected entries {addr, scafull, phase}
  logic [5:0] sb[$];
  bit         m_pend = 1'b0;
  bit         m_full = 1'b0;
  logic [5:0] m_hold = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [5:0] mk_ent(input logic [11:0] din, input logic [2:0] dsca,
                                         input logic lct, input logic en);
    logic ph;
    ph = lct & en;
    if (!dsca[0])      return {din[3:0],  1'b0, ph};
    else if (!dsca[1]) return {din[7:4],  1'b0, ph};
    else if (!dsca[2]) return {din[11:8], 1'b0, ph};
    else               return {din[3:0],  1'b1, ph};
  endfunction

  task automatic drive(input bit push, pop, en, dis, lct, defer, pre,
                       input logic [11:0] din, input logic [2:0] dsca);
    bus0.PUSH = push; bus0.POP = pop; bus0.ENBL50 = en; bus0.DISBL50 = dis;
    bus0.LCT = lct; bus0.LOADPBLK = {defer, 3'b101}; bus0.PREBLKEND = pre;
    bus0.DIN = din; bus0.DSCAFULL = dsca;
    bus1.PUSH = push; bus1.POP = pop; bus1.ENBL50 = en; bus1.DISBL50 = dis;
    bus1.LCT = lct; bus1.LOADPBLK = {defer, 3'b010}; bus1.PREBLKEND = pre;
    bus1.DIN = din; bus1.DSCAFULL = dsca;
  endtask

  task automatic cmp_bus(input string tag, input logic [3:0] dout, input logic [7:0] nlct,
                         input logic ph, input logic sc, input logic f1, input logic eb,
                         input logic f);
    logic [5:0] h;
    int         n;
    n = sb.size();
    h = (n != 0) ? sb[0] : 6'd0;
    check({tag, ".nlct"},  int'(nlct), n);
    check({tag, ".dout"},  int'(dout), int'(h[5:2]));
    check({tag, ".phase"}, int'(ph),   int'(h[0]));
    check({tag, ".scaf"},  int'(sc),   int'(h[1]));
    check({tag, ".full1"}, int'(f1),   (n >= 15) ? 1 : 0);
    check({tag, ".emptb"}, int'(eb),   (n != 0) ? 1 : 0);
    check({tag, ".full"},  int'(f),    m_full ? 1 : 0);
  endtask

  task automatic cmp_both(input string tag);
    cmp_bus({tag, ".t0"}, bus0.DOUT, bus0.NLCT, bus0.LCT_PHASE, bus0.DLSCAFULL,
            bus0.FULL_1, bus0.EMPT_B, bus0.FULL);
    cmp_bus({tag, ".t1"}, bus1.DOUT, bus1.NLCT, bus1.LCT_PHASE, bus1.DLSCAFULL,
            bus1.FULL_1, bus1.EMPT_B, bus1.FULL);
  endtask

  task automatic cycle(input string tag, input bit push, pop, en, dis, lct, defer, pre,
                       input logic [11:0] din, input logic [2:0] dsca);
    bit         act, wr, dopop;
    logic [5:0] wd;
    drive(push, pop, en, dis, lct, defer, pre, din, dsca);
    @(posedge clk);
    #1;
    act = en | dis;
    wr  = 1'b0;
    wd  = '0;
    if (act) begin
      if (push) begin
        if (!defer) begin
          wr = 1'b1;
          wd = mk_ent(din, dsca, lct, en);
        end else begin
          if (m_pend) begin
            wr = 1'b1;
            wd = m_hold;
          end
          m_hold = mk_ent(din, dsca, lct, en);
          m_pend = 1'b1;
        end
      end else if (pre && m_pend) begin
        wr     = 1'b1;
        wd     = m_hold;
        m_pend = 1'b0;
      end
    end
    dopop = act && pop && (sb.size() != 0);
    if (wr && sb.size() == 16 && !dopop) begin
      m_full = 1'b1;
      wr     = 1'b0;
    end
    if (dopop) void'(sb.pop_front());
    if (wr) sb.push_back(wd);
    cmp_both(tag);
  endtask

  task automatic do_reset();
    drive(1, 1, 1, 0, 1, 1, 1, 12'h321, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    m_pend = 1'b0;
    m_full = 1'b0;
    rst    = 1'b1;
    cmp_both("rst");
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      cycle("fill", 1, 0, 1, 0, 1'($urandom_range(0, 1)), 0, 0,
            12'($urandom), 3'($urandom));
  endtask

  initial begin
    bit defer;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    cycle("first", 1, 0, 1, 0, 1, 0, 0, 12'h321, 3'b000);
    check("first.dout", bus0.DOUT, 1);
    check("first.phase", bus0.LCT_PHASE, 1);
    check("first.nlct", bus0.NLCT, 1);
    cycle("selB",  1, 0, 1, 0, 0, 0, 0, 12'h321, 3'b011);
    cycle("selA2", 1, 0, 1, 0, 0, 0, 0, 12'h321, 3'b111);
    cycle("selb",  1, 0, 0, 1, 1, 0, 0, 12'h321, 3'b001);
    cycle("pop1",  0, 1, 0, 1, 0, 0, 0, '0, '0);
    check("sel.c", bus0.DOUT, 3);
    cycle("pop2",  0, 1, 1, 0, 0, 0, 0, '0, '0);
    check("sel.none.dout", bus0.DOUT, 1);
    check("sel.none.scaf", bus0.DLSCAFULL, 1);
    cycle("pop3",  0, 1, 1, 0, 0, 0, 0, '0, '0);
    check("sel.b", bus0.DOUT, 2);
    check("sel.b.phase", bus0.LCT_PHASE, 0);
    repeat (2) cycle("popempty", 0, 1, 1, 0, 0, 0, 0, '0, '0);
    check("popempty.nlct", bus0.NLCT, 0);

    do_reset();
    fill(16);
    check("fill16.nlct", bus0.NLCT, 16);
    check("fill16.full1", bus0.FULL_1, 1);
    check("fill16.full", bus0.FULL, 0);
    fill(1);
    check("ovf.full", bus0.FULL, 1);
    check("ovf.nlct", bus0.NLCT, 16);
    for (int i = 0; i < 16; i++) cycle("drain", 0, 1, 1, 0, 0, 0, 0, '0, '0);
    check("drain.emptb", bus0.EMPT_B, 0);
    check("drain.full", bus0.FULL, 1);

    do_reset();
    fill(16);
    cycle("pushpop16", 1, 1, 1, 0, 1, 0, 0, 12'hABC, 3'b110);
    check("pushpop16.nlct", bus0.NLCT, 16);
    check("pushpop16.full", bus0.FULL, 0);
    cycle("gated", 1, 1, 0, 0, 1, 0, 1, 12'h777, 3'b000);
    check("gated.nlct", bus0.NLCT, 16);

    do_reset();
    cycle("dpush", 1, 0, 1, 0, 1, 1, 0, 12'h654, 3'b000);
    repeat (5) cycle("didle", 0, 0, 1, 0, 0, 1, 0, '0, '0);
    check("defer.nlct0", bus0.NLCT, 0);
    cycle("dcommit", 0, 0, 1, 0, 0, 1, 1, '0, '0);
    check("defer.nlct1", bus0.NLCT, 1);
    check("defer.dout", bus0.DOUT, 4);
    cycle("dpush2", 1, 0, 1, 0, 0, 1, 0, 12'h111, 3'b000);
    cycle("dpush3", 1, 0, 1, 0, 1, 1, 1, 12'h222, 3'b000);
    check("defer.pushpend", bus0.NLCT, 2);
    cycle("dcommit2", 0, 0, 1, 0, 0, 1, 1, '0, '0);
    check("defer.commit2", bus0.NLCT, 3);

    do_reset();
    defer = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit en, dis;
      if (i % 40 == 0) defer = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      dis = en ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle("rand", $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40, en, dis,
            1'($urandom_range(0, 1)), defer, $urandom_range(0, 4) == 0,
            12'($urandom), 3'($urandom));
    end

    do_reset();
    fill(17);
    check("prerst.full", bus0.FULL, 1);
    do_reset();
    check("rst.full", bus0.FULL, 0);
    check("rst.nlct", bus0.NLCT, 0);
    check("rst.dout", bus0.DOUT, 0);
    check("rst.emptb", bus0.EMPT_B, 0);
    check("rst.full1", bus0.FULL_1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
